// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants and helpers for the seven-segment scan controller
package seg_pkg;

    localparam logic [6:0] SEG_BLANK     = 7'h7F;
    localparam int         SLOT_LOG2_MIN = 5;
    localparam int         SLOT_LOG2_MAX = 24;
    localparam int         NDIGITS_MIN   = 2;
    localparam int         NDIGITS_MAX   = 16;

    // Active-low segment pattern, bit order g..a.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = 7'h40;
            4'h1: pat = 7'h79;
            4'h2: pat = 7'h24;
            4'h3: pat = 7'h30;
            4'h4: pat = 7'h19;
            4'h5: pat = 7'h12;
            4'h6: pat = 7'h02;
            4'h7: pat = 7'h78;
            4'h8: pat = 7'h00;
            4'h9: pat = 7'h10;
            4'hA: pat = 7'h08;
            4'hB: pat = 7'h03;
            4'hC: pat = 7'h46;
            4'hD: pat = 7'h21;
            4'hE: pat = 7'h06;
            default: pat = 7'h0E;
        endcase
        return pat;
    endfunction

    function automatic bit slot_log2_ok(input int v);
        return (v >= SLOT_LOG2_MIN) && (v <= SLOT_LOG2_MAX);
    endfunction

    function automatic bit ndigits_ok(input int v);
        return (v >= NDIGITS_MIN) && (v <= NDIGITS_MAX);
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_lz_mask.sv
// rtl/seg_scan_ctrl_lz_mask.sv - leading-zero suppression mask (combinational)
module seg_lz_mask #(
    parameter int NDIGITS = 8
) (
    input  logic [4*NDIGITS-1:0] nibbles,
    input  logic [NDIGITS-1:0]   blank,
    input  logic                 lz_en,
    output logic [NDIGITS-1:0]   suppress
);

    // A blanked digit counts as zero, so it never stops suppression below it.
    always_comb begin
        logic all_zero_above;
        all_zero_above = 1'b1;
        suppress       = '0;
        for (int i = NDIGITS - 1; i >= 1; i--) begin
            all_zero_above = all_zero_above & (blank[i] | (nibbles[4*i +: 4] == 4'd0));
            suppress[i]    = lz_en & all_zero_above;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed seven-segment scanner with frame-synchronous double buffering
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NDIGITS   = 8,
    parameter int SLOT_LOG2 = 18
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [4*NDIGITS-1:0] load_data,
    input  logic [NDIGITS-1:0]   load_dp,
    input  logic [NDIGITS-1:0]   load_blank,
    input  logic                 lz_en,
    input  logic [3:0]           brightness,
    output logic [6:0]           seg,
    output logic                 dp,
    output logic [NDIGITS-1:0]   an,
    output logic                 frame_done
);

    localparam int               IDX_W    = $clog2(NDIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIGITS - 1);

    if (!slot_log2_ok(SLOT_LOG2) || !ndigits_ok(NDIGITS)) begin : g_param_check
        $error("seg_scan_ctrl: NDIGITS or SLOT_LOG2 out of range");
    end

    logic [SLOT_LOG2-1:0] slot_cnt_q, slot_cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 pending_q, pending_d;
    logic [4*NDIGITS-1:0] stage_data_q, stage_data_d, disp_data_q, disp_data_d;
    logic [NDIGITS-1:0]   stage_dp_q, stage_dp_d, disp_dp_q, disp_dp_d;
    logic [NDIGITS-1:0]   stage_blank_q, stage_blank_d, disp_blank_q, disp_blank_d;
    logic                 frame_done_q, frame_done_d;
    logic [NDIGITS-1:0]   an_q, an_d;
    logic [6:0]           seg_q, seg_d;
    logic                 dp_q, dp_d;

    logic [NDIGITS-1:0]   suppress;
    logic                 slot_wrap, boundary, capture, digit_en;
    logic [3:0]           phase, cur_nib;
    logic                 cur_dp, cur_blank, cur_supp;
    logic [NDIGITS-1:0]   cur_onehot;

    seg_lz_mask #(
        .NDIGITS (NDIGITS)
    ) u_lz_mask (
        .nibbles  (disp_data_q),
        .blank    (disp_blank_q),
        .lz_en    (lz_en),
        .suppress (suppress)
    );

    always_comb begin
        slot_wrap = &slot_cnt_q;
        boundary  = slot_wrap && (idx_q == LAST_IDX);
        capture   = load_valid && !pending_q;

        slot_cnt_d = slot_cnt_q + SLOT_LOG2'(1);
        idx_d      = idx_q;
        if (slot_wrap) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end

        stage_data_d  = stage_data_q;
        stage_dp_d    = stage_dp_q;
        stage_blank_d = stage_blank_q;
        if (capture) begin
            stage_data_d  = load_data;
            stage_dp_d    = load_dp;
            stage_blank_d = load_blank;
        end

        // A capture on the boundary edge bypasses staging straight into the display.
        disp_data_d  = disp_data_q;
        disp_dp_d    = disp_dp_q;
        disp_blank_d = disp_blank_q;
        pending_d    = pending_q;
        if (boundary) begin
            if (capture) begin
                disp_data_d  = load_data;
                disp_dp_d    = load_dp;
                disp_blank_d = load_blank;
            end else if (pending_q) begin
                disp_data_d  = stage_data_q;
                disp_dp_d    = stage_dp_q;
                disp_blank_d = stage_blank_q;
            end
            pending_d = 1'b0;
        end else if (capture) begin
            pending_d = 1'b1;
        end

        frame_done_d = boundary;

        cur_nib    = '0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        cur_supp   = 1'b0;
        cur_onehot = '0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib       = disp_data_q[4*i +: 4];
                cur_dp        = disp_dp_q[i];
                cur_blank     = disp_blank_q[i];
                cur_supp      = suppress[i];
                cur_onehot[i] = 1'b1;
            end
        end

        // Slot cycle 0 is the anti-ghosting dead cycle; phase gates PWM duty.
        phase    = slot_cnt_q[SLOT_LOG2-1 -: 4];
        digit_en = (slot_cnt_q != '0) && (phase <= brightness) && !cur_blank && !cur_supp;

        an_d  = digit_en ? ~cur_onehot : '1;
        seg_d = digit_en ? seg_decode(cur_nib) : SEG_BLANK;
        dp_d  = digit_en ? ~cur_dp : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt_q    <= '0;
            idx_q         <= '0;
            pending_q     <= 1'b0;
            stage_data_q  <= '0;
            stage_dp_q    <= '0;
            stage_blank_q <= '0;
            disp_data_q   <= '0;
            disp_dp_q     <= '0;
            disp_blank_q  <= '0;
            frame_done_q  <= 1'b0;
            an_q          <= '1;
            seg_q         <= SEG_BLANK;
            dp_q          <= 1'b1;
        end else begin
            slot_cnt_q    <= slot_cnt_d;
            idx_q         <= idx_d;
            pending_q     <= pending_d;
            stage_data_q  <= stage_data_d;
            stage_dp_q    <= stage_dp_d;
            stage_blank_q <= stage_blank_d;
            disp_data_q   <= disp_data_d;
            disp_dp_q     <= disp_dp_d;
            disp_blank_q  <= disp_blank_d;
            frame_done_q  <= frame_done_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
        end
    end

    assign load_ready = ~pending_q;
    assign frame_done = frame_done_q;
    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - randomized self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

    localparam int ND   = 8;
    localparam int SL   = 5;
    localparam int SLOT = 1 << SL;
    localparam int FRM  = SLOT * ND;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [31:0] load_data = '0;
    logic [7:0]  load_dp = '0;
    logic [7:0]  load_blank = '0;
    logic        lz_en = 1'b0;
    logic [3:0]  brightness = 4'd15;
    logic [6:0]  seg;
    logic        dp;
    logic [7:0]  an;
    logic        frame_done;

    seg_scan_ctrl #(.NDIGITS(ND), .SLOT_LOG2(SL)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_dp    (load_dp),
        .load_blank (load_blank),
        .lz_en      (lz_en),
        .brightness (brightness),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int total = 0;
    int bad   = 0;

    // Reference model: s counts cycles since reset release; buffers follow the handshake rules.
    int          s = 0;
    logic        m_pend = 1'b0;
    logic [31:0] m_sd = '0, m_dd = '0;
    logic [7:0]  m_sdp = '0, m_ddp = '0, m_sb = '0, m_db = '0;
    logic [17:0] exp_v;

    task automatic step();
        logic [7:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp, e_fd, supp, en, cap, bnd;
        int         slot, id;
        if (reset) begin
            e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
            s = 0; m_pend = 1'b0;
            m_sd = '0; m_dd = '0; m_sdp = '0; m_ddp = '0; m_sb = '0; m_db = '0;
        end else begin
            slot = s % SLOT;
            id   = (s / SLOT) % ND;
            supp = lz_en && (id >= 1);
            for (int j = id; j < ND; j++)
                if (!m_db[j] && (m_dd[j*4 +: 4] != 4'd0)) supp = 1'b0;
            en    = (slot != 0) && ((slot / 2) <= int'(brightness)) && !m_db[id] && !supp;
            e_an  = en ? ~(8'd1 << id) : 8'hFF;
            e_seg = en ? seg_tab[m_dd[id*4 +: 4]] : 7'h7F;
            e_dp  = en ? ~m_ddp[id] : 1'b1;
            bnd   = (s % FRM) == (FRM - 1);
            e_fd  = bnd;
            cap   = load_valid && !m_pend;
            if (cap) begin m_sd = load_data; m_sdp = load_dp; m_sb = load_blank; end
            if (bnd) begin
                if (m_pend || cap) begin m_dd = m_sd; m_ddp = m_sdp; m_db = m_sb; end
                m_pend = 1'b0;
            end else if (cap) begin
                m_pend = 1'b1;
            end
            s++;
        end
        @(posedge clk);
        #1;
        exp_v = {e_an, e_seg, e_dp, e_fd, ~m_pend};
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) begin
            step();
            if ({an, seg, dp, frame_done, load_ready} !== exp_v) begin
                bad++; $display("FAIL reset got=%h exp=%h", {an, seg, dp, frame_done, load_ready}, exp_v);
            end
            total++;
        end
    endtask

    task automatic test_basic();
        int last_fd = -1, pulses = 0;
        reset = 1'b0; load_valid = 1'b1; load_data = 32'h1234_ABCD;
        load_dp = '0; load_blank = '0; lz_en = 1'b0; brightness = 4'd15;
        for (int k = 0; k < 3 * FRM; k++) begin
            step();
            load_valid = 1'b0;
            if ({an, seg, dp, frame_done, load_ready} !== exp_v) begin
                bad++; $display("FAIL basic s=%0d got=%h exp=%h", s, {an, seg, dp, frame_done, load_ready}, exp_v);
            end
            total++;
            if (frame_done) begin
                if (last_fd >= 0 && (s - last_fd) != FRM) begin
                    bad++; $display("FAIL fd_period got=%0d exp=%0d", s - last_fd, FRM);
                end
                if (last_fd >= 0) total++;
                last_fd = s; pulses++;
            end
        end
        if (pulses !== 3) begin
            bad++; $display("FAIL fd_count got=%0d exp=3", pulses);
        end
        total++;
    endtask

    task automatic test_midframe_load();
        for (int k = 0; k < 100; k++) begin
            step();
            if ({an, seg, dp, frame_done, load_ready} !== exp_v) begin
                bad++; $display("FAIL mid_pre s=%0d got=%h exp=%h", s, {an, seg, dp, frame_done, load_ready}, exp_v);
            end
            total++;
        end
        load_valid = 1'b1; load_data = 32'h0;
        step();
        load_data = 32'hDEAD_BEEF;
        for (int k = 0; k < 20 + 2 * FRM; k++) begin
            step();
            if (k == 19) load_valid = 1'b0;
            if ({an, seg, dp, frame_done, load_ready} !== exp_v) begin
                bad++; $display("FAIL mid_load s=%0d got=%h exp=%h", s, {an, seg, dp, frame_done, load_ready}, exp_v);
            end
            total++;
        end
    endtask

    task automatic test_coincide();
        int guard = 0;
        while ((s % FRM) != (FRM - 1) && guard < 2 * FRM) begin
            step(); guard++;
            if ({an, seg, dp, frame_done, load_ready} !== exp_v) begin
                bad++; $display("FAIL coin_pre s=%0d got=%h exp=%h", s, {an, seg, dp, frame_done, load_ready}, exp_v);
            end
            total++;
        end
        load_valid = 1'b1; load_data = 32'h5A6F_0E89; load_dp = 8'hA5;
        for (int k = 0; k < FRM + 1; k++) begin
            step();
            load_valid = 1'b0;
            if ({an, seg, dp, frame_done, load_ready} !== exp_v) begin
                bad++; $display("FAIL coincide s=%0d got=%h exp=%h", s, {an, seg, dp, frame_done, load_ready}, exp_v);
            end
            total++;
        end
    endtask

    task automatic test_lz();
        logic [31:0] pats [2] = '{32'h0000_0F00, 32'h0000_0000};
        lz_en = 1'b1; load_dp = '0; load_blank = '0;
        for (int p = 0; p < 2; p++) begin
            load_valid = 1'b1; load_data = pats[p];
            for (int k = 0; k < 2 * FRM; k++) begin
                step();
                load_valid = 1'b0;
                if ({an, seg, dp, frame_done, load_ready} !== exp_v) begin
                    bad++; $display("FAIL lz%0d s=%0d got=%h exp=%h", p, s, {an, seg, dp, frame_done, load_ready}, exp_v);
                end
                total++;
            end
        end
    endtask

    task automatic test_brightness_blank();
        lz_en = 1'b0; brightness = 4'd3;
        load_valid = 1'b1; load_data = 32'h89AB_CDEF; load_dp = 8'h10; load_blank = 8'h0F;
        for (int k = 0; k < 3 * FRM; k++) begin
            step();
            load_valid = 1'b0;
            if (k == 2 * FRM) brightness = 4'd0;
            if ({an, seg, dp, frame_done, load_ready} !== exp_v) begin
                bad++; $display("FAIL bright s=%0d got=%h exp=%h", s, {an, seg, dp, frame_done, load_ready}, exp_v);
            end
            total++;
        end
        load_blank = '0; load_dp = '0; brightness = 4'd15;
    endtask

    task automatic test_random();
        for (int k = 0; k < 6 * FRM; k++) begin
            if ($urandom_range(0, 15) == 0) begin
                load_valid = 1'b1;
                load_data  = $urandom >> $urandom_range(0, 31);
                load_dp    = 8'($urandom);
                load_blank = 8'($urandom & $urandom & $urandom);
            end else if ($urandom_range(0, 3) == 0) begin
                load_valid = 1'b0;
            end
            if ($urandom_range(0, 63) == 0) brightness = 4'($urandom);
            if ($urandom_range(0, 127) == 0) lz_en = ~lz_en;
            step();
            if ({an, seg, dp, frame_done, load_ready} !== exp_v) begin
                bad++; $display("FAIL random s=%0d got=%h exp=%h", s, {an, seg, dp, frame_done, load_ready}, exp_v);
            end
            total++;
        end
        load_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        brightness = 4'd15; lz_en = 1'b0;
        while ((s % FRM) != 50 && guard < 2 * FRM) begin step(); guard++; end
        load_valid = 1'b1; load_data = 32'hFEED_C0DE; load_dp = 8'hFF; load_blank = '0;
        step();
        load_valid = 1'b0;
        repeat (13) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        if ({an, seg, dp, frame_done, load_ready} !== {8'hFF, 7'h7F, 1'b1, 1'b0, 1'b1}) begin
            bad++; $display("FAIL reset_mid got=%h", {an, seg, dp, frame_done, load_ready});
        end
        total++;
        for (int k = 0; k < 2 * FRM; k++) begin
            step();
            if ({an, seg, dp, frame_done, load_ready} !== exp_v) begin
                bad++; $display("FAIL after_reset s=%0d got=%h exp=%h", s, {an, seg, dp, frame_done, load_ready}, exp_v);
            end
            total++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_midframe_load();
        test_coincide();
        test_lz();
        test_brightness_blank();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
